// File: rtl/morse_pkg.sv
// Shared Morse code set, letter table, FSM states and phase lengths in units.
package morse_pkg;

  localparam logic [7:0] CODE_SPACE  = 8'hFF;
  localparam logic [7:0] CODE_PERIOD = 8'h00;
  localparam logic [7:0] CODE_A      = 8'h41;
  localparam logic [7:0] CODE_Z      = 8'h5A;

  localparam int unsigned PAT_W   = 6;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned UNITS_W = 3;

  localparam logic [LEN_W-1:0]   PAT_MAX = 3'd6;
  localparam logic [UNITS_W-1:0] DOT_U   = 3'd1;
  localparam logic [UNITS_W-1:0] DASH_U  = 3'd3;
  localparam logic [UNITS_W-1:0] SYM_U   = 3'd1;
  localparam logic [UNITS_W-1:0] LGAP_U  = 3'd3;
  localparam logic [UNITS_W-1:0] WGAP_U  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MARK   = 3'd1,
    SYMGAP = 3'd2,
    LGAP   = 3'd3,
    WGAP   = 3'd4
  } morse_state_t;

  // pat is right-aligned: pat[len-1] is the first symbol sent, 1 = dash
  typedef struct packed {
    logic             valid;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
  } morse_entry_t;

  // Map a letter code to its Morse pattern; valid=0 for codes outside the table
  function automatic morse_entry_t morse_lookup(input logic [7:0] code);
    morse_entry_t e;
    e = '0;
    if (code == CODE_PERIOD) begin
      e = {1'b1, 3'd6, 6'b010101};
    end else if (code >= CODE_A && code <= CODE_Z) begin
      case (5'(code - CODE_A))
        5'd0:  e = {1'b1, 3'd2, 6'b000001}; // A .-
        5'd1:  e = {1'b1, 3'd4, 6'b001000}; // B -...
        5'd2:  e = {1'b1, 3'd4, 6'b001010}; // C -.-.
        5'd3:  e = {1'b1, 3'd3, 6'b000100}; // D -..
        5'd4:  e = {1'b1, 3'd1, 6'b000000}; // E .
        5'd5:  e = {1'b1, 3'd4, 6'b000010}; // F ..-.
        5'd6:  e = {1'b1, 3'd3, 6'b000110}; // G --.
        5'd7:  e = {1'b1, 3'd4, 6'b000000}; // H ....
        5'd8:  e = {1'b1, 3'd2, 6'b000000}; // I ..
        5'd9:  e = {1'b1, 3'd4, 6'b000111}; // J .---
        5'd10: e = {1'b1, 3'd3, 6'b000101}; // K -.-
        5'd11: e = {1'b1, 3'd4, 6'b000100}; // L .-..
        5'd12: e = {1'b1, 3'd2, 6'b000011}; // M --
        5'd13: e = {1'b1, 3'd2, 6'b000010}; // N -.
        5'd14: e = {1'b1, 3'd3, 6'b000111}; // O ---
        5'd15: e = {1'b1, 3'd4, 6'b000110}; // P .--.
        5'd16: e = {1'b1, 3'd4, 6'b001101}; // Q --.-
        5'd17: e = {1'b1, 3'd3, 6'b000010}; // R .-.
        5'd18: e = {1'b1, 3'd3, 6'b000000}; // S ...
        5'd19: e = {1'b1, 3'd1, 6'b000001}; // T -
        5'd20: e = {1'b1, 3'd3, 6'b000001}; // U ..-
        5'd21: e = {1'b1, 3'd4, 6'b000001}; // V ...-
        5'd22: e = {1'b1, 3'd3, 6'b000011}; // W .--
        5'd23: e = {1'b1, 3'd4, 6'b001001}; // X -..-
        5'd24: e = {1'b1, 3'd4, 6'b001011}; // Y -.--
        5'd25: e = {1'b1, 3'd4, 6'b001100}; // Z --..
        default: e = '0;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit timer: counts UNIT_CYCLES per unit and flags the last tick of a phase.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 2_500_000,
  parameter int unsigned CNT_W       = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               load,
  input  logic [UNITS_W-1:0] load_units,
  output logic               tick_c,
  output logic               phase_end_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0]   unit_cnt;
  logic [UNITS_W-1:0] units_left;

  assign tick_c      = run && (unit_cnt == CNT_LAST);
  assign phase_end_c = tick_c && (units_left == UNITS_W'(1));

  // Phase entry clears the cycle counter and loads the phase length in units
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_cnt   <= '0;
      units_left <= '0;
    end else if (load) begin
      unit_cnt   <= '0;
      units_left <= load_units;
    end else if (run) begin
      if (tick_c) begin
        unit_cnt   <= '0;
        units_left <= units_left - UNITS_W'(1);
      end else begin
        unit_cnt <= unit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/morse_encoder_tx.sv
// Morse transmitter: turns one letter code per handshake into keyed mark/gap timing.
module morse_encoder_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 2_500_000,
  parameter int unsigned CNT_W       = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       letter_valid,
  input  logic [7:0] letter,
  output logic       letter_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       unknown
);

  morse_state_t       state, next_state;
  morse_entry_t       lk;
  logic [PAT_W-1:0]   lk_aligned;
  logic [PAT_W-1:0]   sym_sh;
  logic [LEN_W-1:0]   sym_idx;
  logic [LEN_W-1:0]   sym_len;
  logic               run;
  logic               tmr_load;
  logic [UNITS_W-1:0] tmr_units;
  logic               tick_c;
  logic               phase_end_c;
  logic               latch;
  logic               advance;
  logic               done_d;
  logic               unknown_d;

  assign lk  = morse_lookup(letter);
  assign run = (state != IDLE);

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .load        (tmr_load),
    .load_units  (tmr_units),
    .tick_c      (tick_c),
    .phase_end_c (phase_end_c)
  );

  // Left-align the looked-up pattern so the current symbol is always bit 5
  always_comb begin
    lk_aligned = '0;
    lk_aligned = PAT_W'(lk.pat << (PAT_MAX - lk.len));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state, timer load and pulse decode
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_units  = '0;
    latch      = 1'b0;
    advance    = 1'b0;
    done_d     = 1'b0;
    unknown_d  = 1'b0;
    case (state)
      IDLE: begin
        if (letter_valid && letter_ready) begin
          if (letter == CODE_SPACE) begin
            next_state = WGAP;
            tmr_load   = 1'b1;
            tmr_units  = WGAP_U;
          end else if (lk.valid) begin
            next_state = MARK;
            tmr_load   = 1'b1;
            tmr_units  = lk_aligned[PAT_W-1] ? DASH_U : DOT_U;
            latch      = 1'b1;
          end else begin
            unknown_d = 1'b1;
          end
        end
      end
      MARK: begin
        if (phase_end_c) begin
          tmr_load = 1'b1;
          advance  = 1'b1;
          if (sym_idx == sym_len - LEN_W'(1)) begin
            next_state = LGAP;
            tmr_units  = LGAP_U;
          end else begin
            next_state = SYMGAP;
            tmr_units  = SYM_U;
          end
        end
      end
      SYMGAP: begin
        if (phase_end_c) begin
          next_state = MARK;
          tmr_load   = 1'b1;
          tmr_units  = sym_sh[PAT_W-1] ? DASH_U : DOT_U;
        end
      end
      LGAP, WGAP: begin
        if (phase_end_c) begin
          next_state = IDLE;
          done_d     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Symbol shifter: latched on the handshake, advanced at the end of each mark
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_sh  <= '0;
      sym_idx <= '0;
      sym_len <= '0;
    end else if (latch) begin
      sym_sh  <= lk_aligned;
      sym_idx <= '0;
      sym_len <= lk.len;
    end else if (advance) begin
      sym_sh  <= {sym_sh[PAT_W-2:0], 1'b0};
      sym_idx <= sym_idx + LEN_W'(1);
    end
  end

  // Registered outputs follow the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_out      <= 1'b0;
      letter_ready <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      unknown      <= 1'b0;
    end else begin
      key_out      <= (next_state == MARK);
      letter_ready <= (next_state == IDLE);
      busy         <= (next_state != IDLE);
      done         <= done_d;
      unknown      <= unknown_d;
    end
  end

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Directed bench for morse_encoder_tx with UNIT_CYCLES=4 (dot=4 cycles, dash/letter gap=12, word gap=16).
module tb_morse_encoder_tx;

  localparam int unsigned UNIT_CYCLES = 4;
  localparam int unsigned CNT_W       = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       letter_valid;
  logic [7:0] letter;
  logic       letter_ready;
  logic       key_out;
  logic       busy;
  logic       done;
  logic       unknown;

  int n_assert = 0;
  int n_fail   = 0;

  // Key runs observed while busy: +n = n high cycles, -n = n low cycles
  int         runs[$];
  int         exp_q[$];
  logic [7:0] seq_q[$];
  int         n_idle, n_done, n_unk, t_hs, t_done;
  logic       rdy_at_done;
  logic       timed_out;

  always #5 clk = ~clk;

  morse_encoder_tx #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .letter_valid (letter_valid),
    .letter       (letter),
    .letter_ready (letter_ready),
    .key_out      (key_out),
    .busy         (busy),
    .done         (done),
    .unknown      (unknown)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_runs(input string tag);
    chk({tag, " run count"}, runs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s run%0d", tag, i), (i < runs.size()) ? runs[i] : 0, exp_q[i]);
  endtask

  // Present seq_q back-to-back with valid held; record runs until every code reports done
  task automatic run_seq(input int budget);
    int  idx;
    int  cyc;
    int  cur;
    int  v;
    bit  hs;
    runs.delete();
    n_idle = 0; n_done = 0; n_unk = 0; t_hs = -1; t_done = -1;
    rdy_at_done = 1'b0; timed_out = 1'b0;
    idx = 0; cyc = 0; cur = 0;
    letter       = seq_q[0];
    letter_valid = 1'b1;
    while (n_done < seq_q.size() && !timed_out) begin
      if (done === 1'b1) begin
        n_done++;
        if (t_done < 0) begin
          t_done      = cyc;
          rdy_at_done = letter_ready;
        end
      end
      if (unknown === 1'b1) n_unk++;
      if (busy === 1'b1) begin
        v = (key_out === 1'b1) ? 1 : -1;
        if (cur != 0 && ((cur > 0) == (v > 0))) cur += v;
        else begin
          if (cur != 0) runs.push_back(cur);
          cur = v;
        end
      end else begin
        n_idle++;
      end
      hs = (letter_ready === 1'b1) && letter_valid;
      if (hs && t_hs < 0) t_hs = cyc;
      @(negedge clk);
      cyc++;
      if (hs) begin
        idx++;
        if (idx < seq_q.size()) letter = seq_q[idx];
        else begin
          letter_valid = 1'b0;
          letter       = 8'h45;
        end
      end
      if (cyc >= budget) timed_out = 1'b1;
    end
    if (cur != 0) runs.push_back(cur);
    letter_valid = 1'b0;
    chk("sequence finished within budget", 32'(timed_out), 0);
    chk("done pulse count", n_done, seq_q.size());
    chk("unknown during sequence", n_unk, 0);
  endtask

  initial begin
    int bad;

    // 1: reset and quiet idle
    rst = 1'b1; letter_valid = 1'b0; letter = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset key_out", key_out, 0);
    chk("reset letter_ready", letter_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset unknown", unknown, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (key_out !== 1'b0 || done !== 1'b0 || unknown !== 1'b0 || letter_ready !== 1'b1 || busy !== 1'b0)
        bad++;
    end
    chk("idle cycles disturbed", bad, 0);

    // 2: E, 4 high, 12 low, done 17 cycles after the handshake cycle
    seq_q = '{8'h45};
    run_seq(200);
    exp_q = '{4, -12};
    chk_runs("E");
    chk("E handshake to done cycles", t_done - t_hs, 17);
    chk("E ready in done cycle", rdy_at_done, 1);
    chk("E idle cycles", n_idle, 2);

    // 3: A and period
    seq_q = '{8'h41};
    run_seq(200);
    exp_q = '{4, -4, 12, -12};
    chk_runs("A");
    seq_q = '{8'h00};
    run_seq(400);
    exp_q = '{4, -4, 12, -4, 4, -4, 12, -4, 4, -4, 12, -12};
    chk_runs("period");

    // 4: SOS with valid held; 12 busy-low cycles between letters, one handshake cycle each
    seq_q = '{8'h53, 8'h4F, 8'h53};
    run_seq(600);
    exp_q = '{4, -4, 4, -4, 4, -12, 12, -4, 12, -4, 12, -12, 4, -4, 4, -4, 4, -12};
    chk_runs("SOS");
    chk("SOS idle cycles", n_idle, 4);

    // 5: T then space, 12+16 low after the dash
    seq_q = '{8'h54, 8'hFF};
    run_seq(300);
    exp_q = '{12, -28};
    chk_runs("T space");
    chk("T space idle cycles", n_idle, 3);

    // 5b: unknown code
    letter = 8'h61; letter_valid = 1'b1;
    @(negedge clk);
    letter_valid = 1'b0;
    chk("unknown pulse", unknown, 1);
    chk("unknown ready", letter_ready, 1);
    chk("unknown key", key_out, 0);
    chk("unknown busy", busy, 0);
    @(negedge clk);
    chk("unknown pulse width", unknown, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (key_out !== 1'b0 || done !== 1'b0 || unknown !== 1'b0 || letter_ready !== 1'b1) bad++;
    end
    chk("after unknown disturbed", bad, 0);

    // 6: reset in the second cycle of A's dash
    letter = 8'h41; letter_valid = 1'b1;
    @(negedge clk);
    letter_valid = 1'b0;
    chk("A dot started", key_out, 1);
    repeat (9) @(negedge clk);
    chk("A dash second cycle", key_out, 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset key_out", key_out, 0);
    chk("async reset ready", letter_ready, 1);
    chk("async reset busy", busy, 0);
    letter = 8'h45; letter_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("valid ignored in reset", busy, 0);
    letter_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post reset ready", letter_ready, 1);
    chk("post reset key", key_out, 0);
    seq_q = '{8'h45};
    run_seq(200);
    exp_q = '{4, -12};
    chk_runs("E after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
